fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter WIDTH, default 8: data bits per frame, matching the FIFO word width.
REQ-002 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal values are 2 or more.
REQ-003 Parameter STOP_BITS, default 1: number of stop bits; legal values are 1 or 2.
REQ-004 Port clk, input, 1: the single clock; all state updates occur on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous, active-low.
REQ-006 Port enable, input, 1: permits fetching a new word from the FIFO.
REQ-007 Port fifo_data, input, WIDTH: FIFO data_out.
REQ-008 Port fifo_valid, input, 1: FIFO valid; fifo_data is meaningful while it is high.
REQ-009 Port fifo_empty, input, 1: FIFO empty flag.
REQ-010 Port fifo_rd_en, output, 1: read request to the FIFO.
REQ-011 Port tx, output, 1: serial line, idle high.
REQ-012 Port busy, output, 1: high whenever the state is not IDLE.
REQ-013 Port tx_done, output, 1: single-cycle pulse at the end of each frame.
REQ-014 Port frame_cnt, output, 16: count of completed frames, wrapping.

Function
REQ-015 The state machine shall have the states IDLE, FETCH, START, DATA and STOP.
REQ-016 IDLE: if enable=1 and fifo_empty=0, the block shall drive fifo_rd_en=1 for exactly one cycle and move to FETCH; otherwise it shall stay in IDLE.
REQ-017 fifo_rd_en shall never be high outside the IDLE-to-FETCH transition cycle, so the block never causes a FIFO underflow.
REQ-018 FETCH: on the first cycle with fifo_valid=1, the block shall latch fifo_data into the shift register and move to START; it shall wait indefinitely otherwise, and the read latency is not fixed.
REQ-019 START: tx=0 for CLKS_PER_BIT cycles, then move to DATA.
REQ-020 DATA: WIDTH bits, LSB first, each held for CLKS_PER_BIT cycles; the bit index runs 0..WIDTH-1, then move to STOP.
REQ-021 STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles; tx_done=1 on the last cycle of STOP; frame_cnt increments by 1 on that same edge, wrapping from 0xFFFF to 0; then move to IDLE.
REQ-022 Frame length from the first START cycle to the end of STOP shall be (WIDTH+1+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-023 Back-to-back frames shall have at least 1 IDLE cycle plus the FETCH latency between the end of STOP and the next START.
REQ-024 tx shall be registered and glitch-free; tx=1 in IDLE and FETCH.
REQ-025 If enable is deasserted during FETCH, START, DATA or STOP, the current frame shall complete; enable only gates the IDLE-to-FETCH transition.
REQ-026 fifo_data changing outside the latch cycle shall have no effect on the frame in progress.
REQ-027 The baud counter shall be $clog2(CLKS_PER_BIT) bits wide, reset to 0 on every state change, and count 0..CLKS_PER_BIT-1.

Reset
REQ-028 On rst=0, asynchronously: state=IDLE, tx=1, fifo_rd_en=0, busy=0, tx_done=0, frame_cnt=0, and baud counter, bit index and shift register all 0.
REQ-029 A reset asserted mid-frame shall abort the frame immediately with no tx_done pulse; the partially sent word is lost.
REQ-030 After rst is released, the block shall not assert fifo_rd_en before the first rising edge of clk.

Structure
REQ-031 Package fifo_uart_pkg shall hold the state enum (IDLE, FETCH, START, DATA, STOP) and the default constants for WIDTH, CLKS_PER_BIT and STOP_BITS.
REQ-032 Sub-module uart_baud_cnt shall generate the bit-period tick (inputs: clr, en; output: tick on count CLKS_PER_BIT-1); the FSM, shift register and frame counter shall stay in fifo_uart_tx.

Verification
REQ-033 Scenario: fifo_empty=1, enable=1 for 100 cycles -> fifo_rd_en never high, tx=1, busy=0.
REQ-034 Scenario: one word 0xA5, fifo_valid 1 cycle after rd_en, CLKS_PER_BIT=16 -> exactly one rd_en pulse; tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles; tx_done once; frame_cnt=1.
REQ-035 Scenario: FIFO preloaded with 0x41, 0x22, 0x7D -> three frames in order, exactly 3 rd_en pulses, frame_cnt=3, then IDLE with empty=1.
REQ-036 Scenario: fifo_valid delayed 5 cycles after rd_en -> tx stays 1 during FETCH; START begins the cycle after valid; correct byte sent.
REQ-037 Scenario: rst=0 during DATA bit 3 of 0xFF -> tx=1 immediately, frame_cnt unchanged, no tx_done; the next word is sent cleanly after release.
REQ-038 Scenario: enable dropped during START with 2 words queued -> the current frame completes, no further rd_en until enable=1; STOP_BITS=2 frame length is 176 cycles.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared state encoding and default frame parameters for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

    localparam int DEF_WIDTH        = 8;
    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_STOP_BITS    = 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        STOP
    } state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, pulses tick on the last count.
module uart_baud_cnt
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls words from a FIFO with variable read latency and
// serialises them as start + LSB-first data + stop bits.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int STOP_BITS    = DEF_STOP_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] fifo_data,
    input  logic             fifo_valid,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    output logic             tx,
    output logic             busy,
    output logic             tx_done,
    output logic [15:0]      frame_cnt
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] bit_idx;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_shift;
    logic             baud_en;
    logic             baud_tick;
    logic             state_chg;
    logic             frame_end;
    logic             tx_nxt;

    assign state_chg   = (state != state_nxt);
    assign baud_en     = (state == START) || (state == DATA) || (state == STOP);
    assign frame_end   = (state == STOP) && baud_tick && (bit_idx == LAST_STOP);
    assign shreg_shift = shreg >> 1;

    // Any state change restarts the bit period, so every phase starts at count 0.
    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_chg),
        .en   (baud_en),
        .tick (baud_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable && !fifo_empty)                 state_nxt = FETCH;
            FETCH:   if (fifo_valid)                            state_nxt = START;
            START:   if (baud_tick)                             state_nxt = DATA;
            DATA:    if (baud_tick && (bit_idx == LAST_DATA))   state_nxt = STOP;
            STOP:    if (frame_end)                             state_nxt = IDLE;
            default:                                            state_nxt = IDLE;
        endcase
    end

    // tx is computed from the upcoming state and registered, so the line changes
    // exactly on the edge that enters each bit.
    always_comb begin
        busy    = (state != IDLE);
        tx_done = frame_end;
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = ((state == DATA) && baud_tick) ? shreg_shift[0] : shreg[0];
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx         <= 1'b1;
            fifo_rd_en <= 1'b0;
            shreg      <= '0;
            bit_idx    <= '0;
            frame_cnt  <= '0;
        end else begin
            tx         <= tx_nxt;
            fifo_rd_en <= (state == IDLE) && (state_nxt == FETCH);

            if ((state == FETCH) && fifo_valid) begin
                shreg <= fifo_data;
            end else if ((state == DATA) && baud_tick) begin
                shreg <= shreg_shift;
            end

            // bit_idx indexes data bits in DATA and stop bits in STOP.
            if (state_chg) begin
                bit_idx <= '0;
            end else if (baud_tick) begin
                bit_idx <= bit_idx + 1'b1;
            end

            if (frame_end) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: a behavioural FIFO with programmable read
// latency feeds the default instance; a second instance exercises two stop bits.
module tb_fifo_uart_tx;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  fifo_data = 8'h00;
    logic        fifo_valid = 1'b0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en, tx, busy, tx_done;
    logic [15:0] frame_cnt;

    logic        enable2 = 1'b0;
    logic [7:0]  fifo_data2 = 8'h00;
    logic        fifo_valid2 = 1'b0;
    logic        fifo_empty2 = 1'b1;
    logic        fifo_rd_en2, tx2, busy2, tx_done2;
    logic [15:0] frame_cnt2;

    always #5 clk = ~clk;

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .fifo_data(fifo_data),
        .fifo_valid(fifo_valid), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .tx(tx), .busy(busy), .tx_done(tx_done), .frame_cnt(frame_cnt)
    );

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .enable(enable2), .fifo_data(fifo_data2),
        .fifo_valid(fifo_valid2), .fifo_empty(fifo_empty2), .fifo_rd_en(fifo_rd_en2),
        .tx(tx2), .busy(busy2), .tx_done(tx_done2), .frame_cnt(frame_cnt2)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] q[$];
    logic [7:0] pending = 8'h00;
    int         valid_delay = 1;
    int         vcount = 0;
    int         cyc = 0;
    int         rd_total = 0;
    int         done_total = 0;
    int         valid_cyc = -1;

    // One clock cycle: observe the settled outputs, then update the FIFO model.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (fifo_rd_en === 1'b1) rd_total++;
        if (tx_done === 1'b1) done_total++;
        fifo_valid = 1'b0;
        fifo_data  = ~pending;
        if (vcount > 0) begin
            vcount--;
            if (vcount == 0) begin
                fifo_valid = 1'b1;
                fifo_data  = pending;
                valid_cyc  = cyc;
            end
        end
        if (fifo_rd_en === 1'b1) begin
            pending    = (q.size() > 0) ? q.pop_front() : 8'h00;
            vcount     = valid_delay;
            fifo_empty = (q.size() == 0);
        end
    endtask

    task automatic push(input logic [7:0] w);
        q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        enable      = 1'b0;
        q.delete();
        fifo_empty  = 1'b1;
        vcount      = 0;
        valid_delay = 1;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Records one frame of the default instance: mid-bit samples, length to tx_done,
    // idle cycles before the start bit and whether tx held steady within each bit.
    task automatic capture_frame(input bit drop_en, output logic [9:0] bits, output int len,
                                 output int gap, output int start_cyc, output bit stable,
                                 output bit timeout);
        logic cur;
        bit   finished;
        int   i;
        bits = '0; len = 0; gap = 0; start_cyc = -1; stable = 1'b1; timeout = 1'b0;
        cur = 1'b1; finished = 1'b0; i = 0;
        tick();
        while (tx !== 1'b0 && gap < 300) begin
            gap++;
            tick();
        end
        if (tx !== 1'b0) begin
            timeout = 1'b1;
        end else begin
            start_cyc = cyc;
            if (drop_en) enable = 1'b0;
            while (!finished && i < 400) begin
                if (i % CPB == 0) cur = tx;
                else if (tx !== cur) stable = 1'b0;
                if ((i % CPB == CPB / 2) && (i < 10 * CPB)) bits[i / CPB] = tx;
                if (tx_done === 1'b1) begin
                    finished = 1'b1;
                    len = i + 1;
                end else begin
                    tick();
                    i++;
                end
            end
            if (!finished) timeout = 1'b1;
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", fifo_rd_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_tx_done got %b want 0", tx_done); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
        checks++; if (tx2 !== 1'b1) begin errors++; $display("FAIL reset_tx2 got %b want 1", tx2); end
        tick();
        tick();
        push(8'h00);
        enable = 1'b1;
        rst    = 1'b1;
        #1;
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL release_rd_en got %b want 0", fifo_rd_en); end
        @(posedge clk);
        #1;
        checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL first_edge_rd_en got %b want 1", fifo_rd_en); end
        do_reset();
    endtask

    task automatic test_empty_idle();
        int bad_rd = 0, bad_tx = 0, bad_busy = 0;
        enable = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (fifo_rd_en !== 1'b0) bad_rd++;
            if (tx !== 1'b1) bad_tx++;
            if (busy !== 1'b0) bad_busy++;
        end
        checks++; if (bad_rd != 0) begin errors++; $display("FAIL empty_rd_en got %0d high cycles want 0", bad_rd); end
        checks++; if (bad_tx != 0) begin errors++; $display("FAIL empty_tx got %0d low cycles want 0", bad_tx); end
        checks++; if (bad_busy != 0) begin errors++; $display("FAIL empty_busy got %0d busy cycles want 0", bad_busy); end
        enable = 1'b0;
    endtask

    task automatic test_single_a5();
        logic [9:0] bits;
        int len, gap, sc, r0, d0;
        bit stable, to;
        do_reset();
        r0 = rd_total; d0 = done_total;
        enable = 1'b1;
        push(8'hA5);
        capture_frame(1'b0, bits, len, gap, sc, stable, to);
        checks++; if (to) begin errors++; $display("FAIL a5_timeout got 1 want 0"); end
        checks++; if (bits !== 10'b1101001010) begin errors++; $display("FAIL a5_bits got %b want %b", bits, 10'b1101001010); end
        checks++; if (len != 160) begin errors++; $display("FAIL a5_len got %0d want 160", len); end
        checks++; if (!stable) begin errors++; $display("FAIL a5_stable got 0 want 1"); end
        tick();
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL a5_frame_cnt got %0d want 1", frame_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL a5_busy got %b want 0", busy); end
        checks++; if (rd_total - r0 != 1) begin errors++; $display("FAIL a5_rd_pulses got %0d want 1", rd_total - r0); end
        checks++; if (done_total - d0 != 1) begin errors++; $display("FAIL a5_done_pulses got %0d want 1", done_total - d0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [3] = '{8'h41, 8'h22, 8'h7D};
        logic [9:0] bits;
        int len, gap, sc, r0;
        bit stable, to;
        do_reset();
        r0 = rd_total;
        enable = 1'b1;
        for (int k = 0; k < 3; k++) push(words[k]);
        for (int k = 0; k < 3; k++) begin
            capture_frame(1'b0, bits, len, gap, sc, stable, to);
            checks++;
            if (to || bits !== {1'b1, words[k], 1'b0} || len != 160) begin
                errors++;
                $display("FAIL b2b_frame%0d got bits %b len %0d want bits %b len 160", k, bits, len, {1'b1, words[k], 1'b0});
            end
            if (k > 0) begin
                checks++; if (gap < 2) begin errors++; $display("FAIL b2b_gap%0d got %0d want >=2", k, gap); end
            end
        end
        tick(); tick(); tick();
        checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL b2b_frame_cnt got %0d want 3", frame_cnt); end
        checks++; if (rd_total - r0 != 3) begin errors++; $display("FAIL b2b_rd_pulses got %0d want 3", rd_total - r0); end
        checks++; if (busy !== 1'b0 || fifo_rd_en !== 1'b0) begin errors++; $display("FAIL b2b_idle got busy %b rd_en %b want 0 0", busy, fifo_rd_en); end
        enable = 1'b0;
    endtask

    task automatic test_valid_delay();
        logic [9:0] bits;
        int len, gap, sc;
        bit stable, to;
        do_reset();
        valid_delay = 5;
        enable = 1'b1;
        push(8'hC3);
        capture_frame(1'b0, bits, len, gap, sc, stable, to);
        checks++; if (to || bits !== 10'b1110000110) begin errors++; $display("FAIL delay_bits got %b want %b", bits, 10'b1110000110); end
        checks++; if (sc != valid_cyc + 1) begin errors++; $display("FAIL delay_start got cycle %0d want %0d", sc, valid_cyc + 1); end
        checks++; if (gap < 6) begin errors++; $display("FAIL delay_tx_high got %0d cycles want >=6", gap); end
        tick();
        valid_delay = 1;
        enable = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] bits;
        int len, gap, sc, d0, w;
        bit stable, to;
        do_reset();
        enable = 1'b1;
        push(8'hFF);
        w = 0;
        tick();
        while (tx !== 1'b0 && w < 20) begin w++; tick(); end
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL midrst_start got tx %b want 0", tx); end
        for (int k = 0; k < 70; k++) tick();
        d0 = done_total;
        rst = 1'b0;
        #1;
        checks++; if (tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL midrst_abort got tx %b busy %b want 1 0", tx, busy); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL midrst_frame_cnt got %0d want 0", frame_cnt); end
        tick(); tick();
        rst = 1'b1;
        checks++; if (done_total != d0) begin errors++; $display("FAIL midrst_done got %0d pulses want 0", done_total - d0); end
        push(8'h3C);
        capture_frame(1'b0, bits, len, gap, sc, stable, to);
        checks++; if (to || bits !== 10'b1001111000 || !stable) begin errors++; $display("FAIL midrst_next_bits got %b want %b", bits, 10'b1001111000); end
        tick();
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL midrst_next_cnt got %0d want 1", frame_cnt); end
        checks++; if (done_total - d0 != 1) begin errors++; $display("FAIL midrst_next_done got %0d want 1", done_total - d0); end
        enable = 1'b0;
    endtask

    task automatic test_enable_drop();
        logic [9:0] bits;
        int len, gap, sc, r0;
        bit stable, to;
        do_reset();
        r0 = rd_total;
        enable = 1'b1;
        push(8'h55);
        push(8'h0F);
        capture_frame(1'b1, bits, len, gap, sc, stable, to);
        checks++; if (to || bits !== 10'b1010101010 || len != 160) begin errors++; $display("FAIL endrop_frame got bits %b len %0d want %b 160", bits, len, 10'b1010101010); end
        for (int k = 0; k < 50; k++) tick();
        checks++; if (rd_total - r0 != 1) begin errors++; $display("FAIL endrop_rd_pulses got %0d want 1", rd_total - r0); end
        checks++; if (busy !== 1'b0 || frame_cnt !== 16'd1) begin errors++; $display("FAIL endrop_idle got busy %b cnt %0d want 0 1", busy, frame_cnt); end
        enable = 1'b1;
        capture_frame(1'b0, bits, len, gap, sc, stable, to);
        checks++; if (to || bits !== 10'b1000011110) begin errors++; $display("FAIL endrop_second got %b want %b", bits, 10'b1000011110); end
        tick();
        checks++; if (rd_total - r0 != 2 || frame_cnt !== 16'd2) begin errors++; $display("FAIL endrop_totals got rd %0d cnt %0d want 2 2", rd_total - r0, frame_cnt); end
        enable = 1'b0;
    endtask

    task automatic test_stop_bits();
        logic [9:0] bits;
        int w, i, len, bad_stop;
        bit finished;
        bits = '0; w = 0; i = 0; len = 0; bad_stop = 0; finished = 1'b0;
        fifo_empty2 = 1'b0;
        enable2 = 1'b1;
        tick();
        while (fifo_rd_en2 !== 1'b1 && w < 10) begin w++; tick(); end
        checks++; if (fifo_rd_en2 !== 1'b1) begin errors++; $display("FAIL stop2_rd_en got %b want 1", fifo_rd_en2); end
        fifo_empty2 = 1'b1;
        tick();
        fifo_valid2 = 1'b1;
        fifo_data2  = 8'h96;
        tick();
        fifo_valid2 = 1'b0;
        fifo_data2  = 8'h00;
        w = 0;
        while (tx2 !== 1'b0 && w < 20) begin w++; tick(); end
        while (!finished && i < 400) begin
            if ((i % CPB == CPB / 2) && (i < 10 * CPB)) bits[i / CPB] = tx2;
            if (i >= 9 * CPB && tx2 !== 1'b1) bad_stop++;
            if (tx_done2 === 1'b1) begin
                finished = 1'b1;
                len = i + 1;
            end else begin
                tick();
                i++;
            end
        end
        checks++; if (len != 176) begin errors++; $display("FAIL stop2_len got %0d want 176", len); end
        checks++; if (bits !== 10'b1100101100) begin errors++; $display("FAIL stop2_bits got %b want %b", bits, 10'b1100101100); end
        checks++; if (bad_stop != 0) begin errors++; $display("FAIL stop2_line got %0d low stop cycles want 0", bad_stop); end
        tick();
        checks++; if (frame_cnt2 !== 16'd1 || busy2 !== 1'b0) begin errors++; $display("FAIL stop2_end got cnt %0d busy %b want 1 0", frame_cnt2, busy2); end
        enable2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_empty_idle();
        test_single_a5();
        test_back_to_back();
        test_valid_delay();
        test_reset_mid_frame();
        test_enable_drop();
        test_stop_bits();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
